// File: rtl/writeback_stage_pkg.sv
// Shared constants and the result-buffer entry type used by the writeback stage.
package constants;

  localparam int unsigned WORD_SIZE      = 19;
  // Upper bound on register-index width; narrower indices are zero-extended on push.
  localparam int unsigned REG_ADDR_MAX_W = 8;

  typedef struct packed {
    logic [WORD_SIZE-1:0]      data;
    logic [REG_ADDR_MAX_W-1:0] rd;
    logic                      we;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Circular result buffer with head/tail pointers and an occupancy count.
// DEPTH must be a power of two, so the pointers wrap naturally.
module wb_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter type         entry_t = logic [7:0]
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   push,
  input  logic   pop,
  input  logic   flush,
  input  entry_t push_entry,
  output entry_t head_entry,
  output logic   empty,
  output logic   full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;
  logic [CNT_W-1:0]   count;

  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Storage is deliberately left unreset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (reset && !flush && push) mem[tail] <= push_entry;
  end

  assign head_entry = mem[head];
  assign empty      = (count == '0);
  assign full       = (count == CNT_W'(DEPTH));

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: buffers ALU results and retires them into the register file.
// Define WB_FLAGS_EN to add registered zero/negative flags updated on each retire.
module writeback_stage
  import constants::*;
#(
  parameter int unsigned REG_ADDR_W = 4,
  parameter int unsigned DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [WORD_SIZE-1:0]  alu_result,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic                  alu_we,
  input  logic                  flush,
  input  logic                  rf_ready,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [WORD_SIZE-1:0]  rf_wdata,
  output logic                  empty
`ifdef WB_FLAGS_EN
  ,
  output logic                  flag_z,
  output logic                  flag_n
`endif
);

  wb_entry_t push_entry;
  wb_entry_t head;
  logic      full;
  logic      push;
  logic      pop;
  logic      unused_head_rd;

  always_comb begin
    push_entry      = '0;
    push_entry.data = alu_result;
    push_entry.rd   = REG_ADDR_MAX_W'(alu_rd);
    push_entry.we   = alu_we;
  end

  assign alu_ready = !full;
  assign push      = alu_valid && alu_ready;
  assign pop       = !empty && (rf_ready || !head.we);

  wb_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (wb_entry_t)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .pop        (pop),
    .flush      (flush),
    .push_entry (push_entry),
    .head_entry (head),
    .empty      (empty),
    .full       (full)
  );

  // Strobe is masked during reset so a pending head never writes in the reset cycle.
  assign rf_we          = reset && !empty && head.we;
  assign rf_waddr       = head.rd[REG_ADDR_W-1:0];
  assign rf_wdata       = head.data;
  assign unused_head_rd = ^head.rd;

`ifdef WB_FLAGS_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      flag_z <= 1'b0;
      flag_n <= 1'b0;
    end else if (pop && !flush) begin
      flag_z <= (head.data == '0);
      flag_n <= head.data[WORD_SIZE-1];
    end
  end
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed scenarios plus randomized traffic
// compared every cycle against a queue-based reference model.
module tb_writeback_stage;
  import constants::*;

  localparam int unsigned AW = 4;
  localparam int unsigned DP = 2;

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic                 alu_valid = 1'b0;
  logic                 alu_ready;
  logic [WORD_SIZE-1:0] alu_result = '0;
  logic [AW-1:0]        alu_rd = '0;
  logic                 alu_we = 1'b0;
  logic                 flush = 1'b0;
  logic                 rf_ready = 1'b0;
  logic                 rf_we;
  logic [AW-1:0]        rf_waddr;
  logic [WORD_SIZE-1:0] rf_wdata;
  logic                 empty;
`ifdef WB_FLAGS_EN
  logic                 flag_z;
  logic                 flag_n;
`endif

  int checks = 0;
  int errors = 0;

  writeback_stage #(.REG_ADDR_W(AW), .DEPTH(DP)) dut (
    .clk        (clk),
    .reset      (reset),
    .alu_valid  (alu_valid),
    .alu_ready  (alu_ready),
    .alu_result (alu_result),
    .alu_rd     (alu_rd),
    .alu_we     (alu_we),
    .flush      (flush),
    .rf_ready   (rf_ready),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .empty      (empty)
`ifdef WB_FLAGS_EN
    ,
    .flag_z     (flag_z),
    .flag_n     (flag_n)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an ordered list of pending entries plus the two flags.
  typedef struct {
    logic [WORD_SIZE-1:0] d;
    logic [AW-1:0]        rd;
    logic                 we;
  } mentry_t;

  mentry_t q[$];
  bit      model_init = 1'b0;
  bit      mz = 1'b0;
  bit      mn = 1'b0;
  bit      m_pop;
  bit      m_push;

  always @(posedge clk) begin
    if (!reset) begin
      q.delete();
      mz = 1'b0;
      mn = 1'b0;
      model_init = 1'b1;
    end else if (flush) begin
      q.delete();
    end else begin
      m_pop  = (q.size() > 0) && (rf_ready || !q[0].we);
      m_push = alu_valid && (q.size() < DP);
      if (m_pop) begin
        mz = (q[0].d == 0);
        mn = q[0].d[WORD_SIZE-1];
        void'(q.pop_front());
      end
      if (m_push) q.push_back('{alu_result, alu_rd, alu_we});
    end
  end

  always @(negedge clk) begin
    if (model_init) begin
      chk("empty", 32'(empty), 32'(q.size() == 0));
      chk("alu_ready", 32'(alu_ready), 32'(q.size() < DP));
      chk("rf_we", 32'(rf_we), 32'(reset && q.size() > 0 && q[0].we));
      if (q.size() > 0) begin
        chk("rf_waddr", 32'(rf_waddr), 32'(q[0].rd));
        chk("rf_wdata", 32'(rf_wdata), 32'(q[0].d));
      end
`ifdef WB_FLAGS_EN
      chk("flag_z", 32'(flag_z), 32'(mz));
      chk("flag_n", 32'(flag_n), 32'(mn));
`endif
    end
  end

  task automatic drive(input bit v, input logic [WORD_SIZE-1:0] d, input logic [AW-1:0] rd,
                       input bit we, input bit rr, input bit fl, input bit rst);
    @(negedge clk);
    #1;
    alu_valid  = v;
    alu_result = d;
    alu_rd     = rd;
    alu_we     = we;
    rf_ready   = rr;
    flush      = fl;
    reset      = rst;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset
    drive(0, '0, '0, 0, 0, 0, 0);
    tick();
    tick();
    chk("reset_empty", 32'(empty), 1);
    chk("reset_ready", 32'(alu_ready), 1);
    chk("reset_rf_we", 32'(rf_we), 0);
`ifdef WB_FLAGS_EN
    chk("reset_flag_z", 32'(flag_z), 0);
    chk("reset_flag_n", 32'(flag_n), 0);
`endif

    // Single write
    drive(1, 19'h7FFFF, 4'd3, 1, 1, 0, 1);
    tick();
    chk("single_rf_we", 32'(rf_we), 1);
    chk("single_waddr", 32'(rf_waddr), 3);
    chk("single_wdata", 32'(rf_wdata), 32'h7FFFF);
    drive(0, '0, '0, 0, 1, 0, 1);
    tick();
    chk("single_empty", 32'(empty), 1);
`ifdef WB_FLAGS_EN
    chk("single_flag_n", 32'(flag_n), 1);
    chk("single_flag_z", 32'(flag_z), 0);
`endif

    // Backpressure
    drive(1, 19'h00001, 4'd1, 1, 0, 0, 1);
    tick();
    drive(1, 19'h00002, 4'd2, 1, 0, 0, 1);
    tick();
    chk("bp_ready_low", 32'(alu_ready), 0);
    drive(1, 19'h00003, 4'd3, 1, 0, 0, 1);
    tick();
    chk("bp_head_held", 32'(rf_wdata), 1);
    chk("bp_still_full", 32'(alu_ready), 0);
    drive(0, '0, '0, 0, 1, 0, 1);
    chk("bp_first_we", 32'(rf_we), 1);
    chk("bp_first_data", 32'(rf_wdata), 1);
    tick();
    chk("bp_second_we", 32'(rf_we), 1);
    chk("bp_second_data", 32'(rf_wdata), 2);
    tick();
    chk("bp_third_lost", 32'(empty), 1);

    // No-write retire
    drive(1, 19'h00000, 4'd5, 0, 0, 0, 1);
    tick();
    chk("nw_rf_we", 32'(rf_we), 0);
    chk("nw_present", 32'(empty), 0);
    chk("nw_waddr", 32'(rf_waddr), 5);
    drive(0, '0, '0, 0, 0, 0, 1);
    tick();
    chk("nw_retired", 32'(empty), 1);
`ifdef WB_FLAGS_EN
    chk("nw_flag_z", 32'(flag_z), 1);
    chk("nw_flag_n", 32'(flag_n), 0);
`endif

    // Flush priority
    drive(1, 19'h00011, 4'd1, 1, 0, 0, 1);
    tick();
    drive(1, 19'h40022, 4'd2, 1, 0, 0, 1);
    tick();
    chk("fl_full", 32'(alu_ready), 0);
    drive(1, 19'h00123, 4'd4, 1, 1, 1, 1);
    tick();
    chk("fl_empty", 32'(empty), 1);
    chk("fl_no_we", 32'(rf_we), 0);
    drive(0, '0, '0, 0, 1, 0, 1);
    tick();
    chk("fl_push_lost", 32'(empty), 1);
`ifdef WB_FLAGS_EN
    chk("fl_flag_z_kept", 32'(flag_z), 1);
`endif

    // Streaming
    for (int i = 1; i <= 8; i++) begin
      drive(1, 19'(i), 4'(i), 1, 1, 0, 1);
      tick();
      chk("st_we", 32'(rf_we), 1);
      chk("st_data", 32'(rf_wdata), 32'(i));
      chk("st_ready", 32'(alu_ready), 1);
    end
    drive(0, '0, '0, 0, 1, 0, 1);
    tick();
    chk("st_drained", 32'(empty), 1);

    // Reset mid-operation
    drive(1, 19'h00009, 4'd2, 1, 0, 0, 1);
    tick();
    drive(0, '0, '0, 0, 1, 0, 0);
    #1;
    chk("mr_we_in_reset", 32'(rf_we), 0);
    tick();
    chk("mr_we_after", 32'(rf_we), 0);
    chk("mr_empty", 32'(empty), 1);
    drive(0, '0, '0, 0, 1, 0, 1);
    tick();
    chk("mr_still_empty", 32'(empty), 1);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      logic [WORD_SIZE-1:0] d;
      d = ($urandom_range(0, 7) == 0) ? '0 : WORD_SIZE'($urandom);
      drive($urandom_range(0, 9) < 7, d, AW'($urandom), $urandom_range(0, 3) != 0,
            $urandom_range(0, 1) == 1, $urandom_range(0, 19) == 0,
            $urandom_range(0, 49) != 0);
    end
    drive(0, '0, '0, 0, 1, 0, 1);
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
